// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//
// Resolves LEGv8 branch decisions (B, CBZ, CBNZ, B.cond) for the 64-bit core.
// Holds the architectural NZCV flags register, written from ALU results, and
// returns a registered taken/target result to fetch behind a valid/ready
// handshake. One accepted branch per cycle while the consumer keeps up.
//
// Optional feature macro: BRANCH_RESOLVER_FLAG_FWD_EN
//   defined   : a B.cond accepted in the same cycle as set_flags_i evaluates
//               against the incoming flags derived from the ALU inputs.
//   undefined : B.cond always evaluates the registered flags (old value).
//
// Ports:
//   clk_i, rst_n_i         clock (rising edge), async active-low reset
//   set_flags_i            latch NZCV from the current ALU result
//   alu_result_i           ALU result (N = MSB, Z = all zero)
//   alu_carry_i            ALU carry-out (C)
//   alu_overflow_i         ALU signed overflow (V)
//   br_valid_i/br_ready_o  branch request handshake
//   br_type_i              00 B, 01 CBZ, 10 CBNZ, 11 B.cond
//   cond_i                 B.cond condition code
//   operand_i              CBZ/CBNZ register operand
//   pc_i, offset_i         branch PC and pre-scaled, sign-extended offset
//   flush_i                drop the held result, block accepts this cycle
//   res_valid_o/res_ready_i result handshake
//   taken_o, target_o      registered decision and pc_i + offset_i
//   flags_o                {N,Z,C,V} register
//
// Output register states:
//   state | meaning
//   EMPTY | no result held, res_valid_o = 0
//   FULL  | result held, taken_o/target_o stable until consumed or flushed
// -----------------------------------------------------------------------------
module branch_resolver #(
  parameter int REGISTER_LENGTH = 64,
  parameter int ADDR_LENGTH     = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       set_flags_i,
  input  logic [REGISTER_LENGTH-1:0] alu_result_i,
  input  logic                       alu_carry_i,
  input  logic                       alu_overflow_i,
  input  logic                       br_valid_i,
  output logic                       br_ready_o,
  input  logic [1:0]                 br_type_i,
  input  logic [3:0]                 cond_i,
  input  logic [REGISTER_LENGTH-1:0] operand_i,
  input  logic [ADDR_LENGTH-1:0]     pc_i,
  input  logic [ADDR_LENGTH-1:0]     offset_i,
  input  logic                       flush_i,
  output logic                       res_valid_o,
  input  logic                       res_ready_i,
  output logic                       taken_o,
  output logic [ADDR_LENGTH-1:0]     target_o,
  output logic [3:0]                 flags_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic [1:0] TYPE_B     = 2'b00;
  localparam logic [1:0] TYPE_CBZ   = 2'b01;
  localparam logic [1:0] TYPE_CBNZ  = 2'b10;
  localparam logic [1:0] TYPE_BCOND = 2'b11;

  state_t                  state_q, state_d;
  logic [3:0]              flags_q;
  logic [3:0]              flags_new;
  logic [3:0]              flags_eval;
  logic                    taken_q;
  logic [ADDR_LENGTH-1:0]  target_q;
  logic                    accept;
  logic                    taken_d;
  logic                    operand_zero;

  // Condition codes pair up: odd codes invert the even code below them,
  // except 1110/1111 which are both "always".
  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, base;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    case (cond[3:1])
      3'd0:    base = z;
      3'd1:    base = c;
      3'd2:    base = n;
      3'd3:    base = v;
      3'd4:    base = c & ~z;
      3'd5:    base = (n == v);
      3'd6:    base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    cond_holds = (cond[3:1] == 3'd7) ? 1'b1 : (base ^ cond[0]);
  endfunction

  assign flags_new = {alu_result_i[REGISTER_LENGTH-1],
                      (alu_result_i == '0),
                      alu_carry_i,
                      alu_overflow_i};

`ifdef BRANCH_RESOLVER_FLAG_FWD_EN
  assign flags_eval = set_flags_i ? flags_new : flags_q;
`else
  assign flags_eval = flags_q;
`endif

  assign operand_zero = (operand_i == '0);

  always_comb begin
    taken_d = 1'b0;
    case (br_type_i)
      TYPE_B:     taken_d = 1'b1;
      TYPE_CBZ:   taken_d = operand_zero;
      TYPE_CBNZ:  taken_d = ~operand_zero;
      TYPE_BCOND: taken_d = cond_holds(cond_i, flags_eval);
      default:    taken_d = 1'b0;
    endcase
  end

  // Next-state and handshake. Flush wins over everything and also closes
  // the request port so a branch presented during a flush is not lost
  // silently inside the resolver.
  always_comb begin
    state_d    = state_q;
    br_ready_o = 1'b0;
    accept     = 1'b0;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      br_ready_o = (state_q == EMPTY) || res_ready_i;
      accept     = br_valid_i && br_ready_o;
      if (accept) begin
        state_d = FULL;
      end else if ((state_q == FULL) && res_ready_i) begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      taken_q  <= 1'b0;
      target_q <= '0;
    end else if (accept) begin
      taken_q  <= taken_d;
      target_q <= pc_i + offset_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flags_q <= 4'b0000;
    end else if (set_flags_i) begin
      flags_q <= flags_new;
    end
  end

  assign res_valid_o = (state_q == FULL);
  assign taken_o     = taken_q;
  assign target_o    = target_q;
  assign flags_o     = flags_q;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;

  localparam int RL = 64;
  localparam int AL = 64;
`ifdef BRANCH_RESOLVER_FLAG_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          set_flags_i;
  logic [RL-1:0] alu_result_i;
  logic          alu_carry_i;
  logic          alu_overflow_i;
  logic          br_valid_i;
  logic          br_ready_o;
  logic [1:0]    br_type_i;
  logic [3:0]    cond_i;
  logic [RL-1:0] operand_i;
  logic [AL-1:0] pc_i;
  logic [AL-1:0] offset_i;
  logic          flush_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic          taken_o;
  logic [AL-1:0] target_o;
  logic [3:0]    flags_o;

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model state
  logic          m_valid;
  logic          m_taken;
  logic [AL-1:0] m_target;
  logic [3:0]    m_flags;

  branch_resolver #(.REGISTER_LENGTH(RL), .ADDR_LENGTH(AL)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .set_flags_i(set_flags_i),
    .alu_result_i(alu_result_i), .alu_carry_i(alu_carry_i),
    .alu_overflow_i(alu_overflow_i), .br_valid_i(br_valid_i),
    .br_ready_o(br_ready_o), .br_type_i(br_type_i), .cond_i(cond_i),
    .operand_i(operand_i), .pc_i(pc_i), .offset_i(offset_i),
    .flush_i(flush_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
    .taken_o(taken_o), .target_o(target_o), .flags_o(flags_o)
  );

  always #5 clk_i = ~clk_i;

  // Condition table written straight from the architectural list.
  function automatic logic ref_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !(c && !z);
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return !(!z && (n == v));
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [1:0] t, input logic [3:0] cond,
                                     input logic [RL-1:0] op, input logic [3:0] f);
    if (t == 2'b00) return 1'b1;
    if (t == 2'b01) return op == 0;
    if (t == 2'b10) return op != 0;
    return ref_cond(cond, f);
  endfunction

  function automatic logic ref_ready();
    return !flush_i && (!m_valid || res_ready_i);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_taken = 1'b0; m_target = '0; m_flags = 4'b0000;
  endtask

  // Apply one clock edge to the model using the inputs present at the edge.
  task automatic model_update();
    logic [3:0] nf, ef;
    logic       acc;
    nf  = {alu_result_i[RL-1], alu_result_i == 0, alu_carry_i, alu_overflow_i};
    ef  = (FWD && set_flags_i) ? nf : m_flags;
    acc = br_valid_i && ref_ready();
    if (flush_i) m_valid = 1'b0;
    else if (acc) begin
      m_valid  = 1'b1;
      m_taken  = ref_taken(br_type_i, cond_i, operand_i, ef);
      m_target = pc_i + offset_i;
    end else if (m_valid && res_ready_i) m_valid = 1'b0;
    if (set_flags_i) m_flags = nf;
  endtask

  task automatic cycle();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic idle();
    set_flags_i = 0; alu_result_i = '0; alu_carry_i = 0; alu_overflow_i = 0;
    br_valid_i = 0; br_type_i = 2'b00; cond_i = 4'h0; operand_i = '0;
    pc_i = '0; offset_i = '0; flush_i = 0; res_ready_i = 1;
  endtask

  task automatic request(input logic [1:0] t, input logic [3:0] cond,
                         input logic [RL-1:0] op, input logic [AL-1:0] pc,
                         input logic [AL-1:0] off);
    br_valid_i = 1; br_type_i = t; cond_i = cond; operand_i = op;
    pc_i = pc; offset_i = off;
  endtask

  task automatic test_reset();
    tests_run++;
    if (res_valid_o !== 1'b0 || flags_o !== 4'b0000 || taken_o !== 1'b0 || target_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_initial: valid=%b flags=%b taken=%b target=%h, want 0", res_valid_o, flags_o, taken_o, target_o);
    end
    @(negedge clk_i);
    rst_n_i = 1;
    #1;
    tests_run++;
    if (br_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready: got %b want 1", br_ready_o);
    end
    // Fill the output register and the flags, then reset mid-cycle.
    set_flags_i = 1; alu_result_i = 64'd1; alu_carry_i = 1;
    request(2'b00, 4'h0, '0, 64'h1000, 64'h4);
    cycle();
    idle();
    tests_run++;
    if (res_valid_o !== 1'b1 || flags_o !== 4'b0010) begin
      tests_failed++;
      $display("FAIL reset_prefill: valid=%b flags=%b want 1 0010", res_valid_o, flags_o);
    end
    #2 rst_n_i = 0;
    #1;
    model_reset();
    tests_run++;
    if (res_valid_o !== 1'b0 || flags_o !== 4'b0000 || taken_o !== 1'b0 || target_o !== '0) begin
      tests_failed++;
      $display("FAIL reset_async: valid=%b flags=%b taken=%b target=%h, want 0", res_valid_o, flags_o, taken_o, target_o);
    end
    #1 rst_n_i = 1;
    #1;
    tests_run++;
    if (br_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: ready=%b valid=%b want 1 0", br_ready_o, res_valid_o);
    end
  endtask

  task automatic test_cbz_cbnz();
    idle();
    request(2'b01, 4'h0, '0, 64'h100, 64'h40);
    cycle();
    tests_run++;
    if (res_valid_o !== 1'b1 || taken_o !== 1'b1 || target_o !== 64'h140) begin
      tests_failed++;
      $display("FAIL cbz_zero: valid=%b taken=%b target=%h want 1 1 140", res_valid_o, taken_o, target_o);
    end
    request(2'b10, 4'h0, '0, 64'h100, 64'h40);
    cycle();
    tests_run++;
    if (res_valid_o !== 1'b1 || taken_o !== 1'b0 || target_o !== 64'h140) begin
      tests_failed++;
      $display("FAIL cbnz_zero: valid=%b taken=%b target=%h want 1 0 140", res_valid_o, taken_o, target_o);
    end
    request(2'b10, 4'h0, 64'h8000_0000_0000_0000, 64'h100, 64'h40);
    cycle();
    tests_run++;
    if (taken_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL cbnz_nonzero: taken=%b want 1", taken_o);
    end
    idle();
    cycle();
    tests_run++;
    if (res_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL cbz_drain: valid=%b want 0", res_valid_o);
    end
  endtask

  task automatic test_flags_cond();
    logic [3:0] conds [3];
    logic       exp   [3];
    conds = '{4'hB, 4'h8, 4'h0};
    exp   = '{1'b1, 1'b1, 1'b0};
    idle();
    set_flags_i = 1; alu_result_i = '1; alu_carry_i = 1; alu_overflow_i = 0;
    cycle();
    idle();
    tests_run++;
    if (flags_o !== 4'b1010) begin
      tests_failed++;
      $display("FAIL flags_set: got %b want 1010", flags_o);
    end
    for (int i = 0; i < 3; i++) begin
      request(2'b11, conds[i], '0, 64'h2000, 64'h10);
      cycle();
      tests_run++;
      if (res_valid_o !== 1'b1 || taken_o !== exp[i]) begin
        tests_failed++;
        $display("FAIL bcond_%h: valid=%b taken=%b want 1 %b", conds[i], res_valid_o, taken_o, exp[i]);
      end
    end
    idle();
    cycle();
  endtask

  task automatic test_forwarding();
    idle();
    request(2'b11, 4'h0, '0, 64'h3000, 64'h8);
    set_flags_i = 1; alu_result_i = '0;
    cycle();
    idle();
    tests_run++;
    if (taken_o !== FWD || target_o !== 64'h3008) begin
      tests_failed++;
      $display("FAIL fwd_eq: taken=%b target=%h want %b 3008", taken_o, target_o, FWD);
    end
    tests_run++;
    if (flags_o !== 4'b0100) begin
      tests_failed++;
      $display("FAIL fwd_flags: got %b want 0100", flags_o);
    end
    cycle();
  endtask

  task automatic test_backpressure();
    idle();
    res_ready_i = 0;
    request(2'b00, 4'h0, '0, 64'h200, 64'h8);
    cycle();
    request(2'b01, 4'h0, 64'd5, 64'h300, 64'h10);
    #1;
    tests_run++;
    if (br_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_ready_low: got %b want 0", br_ready_o);
    end
    for (int i = 0; i < 2; i++) begin
      cycle();
      tests_run++;
      if (res_valid_o !== 1'b1 || taken_o !== 1'b1 || target_o !== 64'h208) begin
        tests_failed++;
        $display("FAIL bp_hold: valid=%b taken=%b target=%h want 1 1 208", res_valid_o, taken_o, target_o);
      end
    end
    res_ready_i = 1;
    #1;
    tests_run++;
    if (br_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_release: got %b want 1", br_ready_o);
    end
    cycle();
    tests_run++;
    if (res_valid_o !== 1'b1 || taken_o !== 1'b0 || target_o !== 64'h310) begin
      tests_failed++;
      $display("FAIL bp_second: valid=%b taken=%b target=%h want 1 0 310", res_valid_o, taken_o, target_o);
    end
    idle();
    cycle();
  endtask

  task automatic test_wrap_flush();
    logic [3:0] f_before;
    idle();
    request(2'b00, 4'h0, '0, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20);
    cycle();
    tests_run++;
    if (res_valid_o !== 1'b1 || target_o !== 64'h10) begin
      tests_failed++;
      $display("FAIL wrap_target: valid=%b target=%h want 1 10", res_valid_o, target_o);
    end
    f_before = m_flags;
    res_ready_i = 0;
    flush_i = 1;
    request(2'b00, 4'h0, '0, 64'h500, 64'h4);
    #1;
    tests_run++;
    if (br_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_ready: got %b want 0", br_ready_o);
    end
    cycle();
    idle();
    tests_run++;
    if (res_valid_o !== 1'b0 || flags_o !== f_before) begin
      tests_failed++;
      $display("FAIL flush_empty: valid=%b flags=%b want 0 %b", res_valid_o, flags_o, f_before);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_flags_i    = ($urandom_range(0, 2) == 0);
      alu_result_i   = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
      alu_carry_i    = $urandom_range(0, 1);
      alu_overflow_i = $urandom_range(0, 1);
      br_valid_i     = ($urandom_range(0, 3) != 0);
      br_type_i      = 2'($urandom_range(0, 3));
      cond_i         = 4'($urandom_range(0, 15));
      operand_i      = ($urandom_range(0, 2) == 0) ? '0 : {$urandom, $urandom};
      pc_i           = {$urandom, $urandom};
      offset_i       = {$urandom, $urandom};
      flush_i        = ($urandom_range(0, 9) == 0);
      res_ready_i    = ($urandom_range(0, 9) < 7);
      #1;
      tests_run++;
      if (br_ready_o !== ref_ready()) begin
        tests_failed++;
        $display("FAIL rnd_ready[%0d]: got %b want %b", i, br_ready_o, ref_ready());
      end
      cycle();
      tests_run++;
      if (res_valid_o !== m_valid || flags_o !== m_flags) begin
        tests_failed++;
        $display("FAIL rnd_state[%0d]: valid=%b flags=%b want %b %b", i, res_valid_o, flags_o, m_valid, m_flags);
      end
      if (m_valid) begin
        tests_run++;
        if (taken_o !== m_taken || target_o !== m_target) begin
          tests_failed++;
          $display("FAIL rnd_result[%0d]: taken=%b target=%h want %b %h", i, taken_o, target_o, m_taken, m_target);
        end
      end
    end
    idle();
    cycle();
  endtask

  initial begin
    idle();
    model_reset();
    rst_n_i = 0;
    #1;
    test_reset();
    test_cbz_cbnz();
    test_flags_cond();
    test_forwarding();
    test_backpressure();
    test_wrap_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Resolves LEGv8 branch decisions for the 64-bit CPU. It holds the architectural NZCV flags register, written from ALU results, and evaluates B, CBZ, CBNZ and B.cond requests. Each accepted request produces a registered taken/target result behind a valid/ready handshake. It sits between the execute stage (ALU result and flags) and the fetch stage (PC redirect).

## Interface
Parameters:
- REGISTER_LENGTH, 64, width of ALU result and CBZ/CBNZ operand
- ADDR_LENGTH, 64, width of PC, offset and target

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  asynchronous active-low reset
- set_flags_i  in  1  latch NZCV from the current ALU result
- alu_result_i  in  REGISTER_LENGTH  ALU result
- alu_carry_i  in  1  ALU carry-out
- alu_overflow_i  in  1  ALU signed overflow
- br_valid_i  in  1  branch request valid
- br_ready_o  out  1  request can be accepted this cycle
- br_type_i  in  2  00 B, 01 CBZ, 10 CBNZ, 11 B.cond
- cond_i  in  4  B.cond condition code
- operand_i  in  REGISTER_LENGTH  CBZ/CBNZ register operand
- pc_i  in  ADDR_LENGTH  PC of the branch
- offset_i  in  ADDR_LENGTH  byte offset, already sign-extended and shifted
- flush_i  in  1  synchronous drop of the held result
- res_valid_o  out  1  result valid
- res_ready_i  in  1  consumer accepts the result
- taken_o  out  1  branch taken
- target_o  out  ADDR_LENGTH  pc_i + offset_i, modulo 2^ADDR_LENGTH
- flags_o  out  4  {N,Z,C,V} register

## Operation
- Flags register:
  - On a clock edge with set_flags_i=1: N=alu_result_i[MSB], Z=(alu_result_i==0), C=alu_carry_i, V=alu_overflow_i.
  - Otherwise the register holds.
  - Flag updates are independent of the branch handshake.
- Output register has two states:
  - EMPTY (res_valid_o=0).
  - FULL (res_valid_o=1; taken_o and target_o are stable).
- br_ready_o = !res_valid_o || res_ready_i. This is combinational and allows back-to-back acceptance.
- Accept = br_valid_i && br_ready_o. An accept loads taken and target and moves the state to FULL.
- FULL with res_ready_i=1 and no accept moves to EMPTY.
- FULL with res_ready_i=0 holds all outputs unchanged.
- Taken rules:
  - B: always taken.
  - CBZ: taken when operand_i==0.
  - CBNZ: taken when operand_i!=0.
  - B.cond: taken according to cond_i:
    - 0 EQ: Z
    - 1 NE: !Z
    - 2 HS: C
    - 3 LO: !C
    - 4 MI: N
    - 5 PL: !N
    - 6 VS: V
    - 7 VC: !V
    - 8 HI: C&!Z
    - 9 LS: !(C&!Z)
    - A GE: N==V
    - B LT: N!=V
    - C GT: !Z&(N==V)
    - D LE: !(!Z&(N==V))
    - E and F AL: 1
- target_o is computed for every type, including not-taken branches. Addition wraps with no overflow indication.
- flush_i=1 forces the state to EMPTY on the next edge and blocks any accept that cycle (br_ready_o=0). Flags are not affected.

## Timing
- Reset (asynchronous, immediate): res_valid_o=0, taken_o=0, target_o=0, flags_o=0000. br_ready_o=1 once reset is released.
- Latency: an accept at edge k gives res_valid_o=1 with the result after edge k, so one cycle.
- Throughput: one branch per cycle while res_ready_i=1.
- Simultaneous set_flags_i and a B.cond accept: the flag source depends on the macro (see Configuration).
- Reset asserted while FULL: the held result is lost. The consumer must ignore a result that was mid-handshake.

## Configuration
- BRANCH_RESOLVER_FLAG_FWD_EN defined: a B.cond accepted in the same cycle as set_flags_i=1 evaluates against the incoming flags computed from alu_result_i, alu_carry_i and alu_overflow_i.
- BRANCH_RESOLVER_FLAG_FWD_EN undefined: B.cond always evaluates the registered flags_o, i.e. the old value. Software must place one instruction between a flag-setting instruction and a dependent B.cond.

## Test plan
- Reset test: assert rst_n_i mid-cycle while FULL -> res_valid_o=0, flags_o=0000 immediately; br_ready_o=1 after release.
- CBZ/CBNZ:
  - CBZ with operand 0, pc 0x100, offset 0x40 -> taken_o=1, target_o=0x140 one cycle later.
  - CBNZ with operand 0 -> taken_o=0, target_o=0x140.
- Flags and conditions: set_flags_i with result 0xFFFF_FFFF_FFFF_FFFF, C=1, V=0 -> flags_o=1010. Then:
  - B.cond LT -> taken.
  - B.cond HI -> taken.
  - B.cond EQ -> not taken.
- Forwarding: set_flags_i with result 0 in the same cycle as a B.cond EQ request, old Z=0 -> taken_o=1 with the macro defined, 0 without it.
- Backpressure: hold res_ready_i=0 with FULL and issue a new request -> br_ready_o=0, outputs unchanged. Release res_ready_i -> second result appears the next cycle.
- Wrap and flush:
  - pc 0xFFFF_FFFF_FFFF_FFF0 with offset 0x20 -> target_o=0x10.
  - flush_i while FULL -> res_valid_o=0 next cycle, flags unchanged.
